// File: rtl/arm_mul_seq_if.sv
// Operation request/result bundle between the execute stage (master) and the
// multi-cycle multiply unit arm_mul_seq (slave).
interface arm_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             mul_start;
  logic [2:0]       mul_op;
  logic [WIDTH-1:0] mul_rm;
  logic [WIDTH-1:0] mul_rs;
  logic [WIDTH-1:0] mul_acc_lo;
  logic [WIDTH-1:0] mul_acc_hi;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_res_lo;
  logic [WIDTH-1:0] mul_res_hi;
  logic             mul_n;
  logic             mul_z;
  logic             mul_und;

  modport master (
    output mul_start, mul_op, mul_rm, mul_rs, mul_acc_lo, mul_acc_hi,
    input  mul_busy, mul_done, mul_res_lo, mul_res_hi, mul_n, mul_z, mul_und
  );

  modport slave (
    input  mul_start, mul_op, mul_rm, mul_rs, mul_acc_lo, mul_acc_hi,
    output mul_busy, mul_done, mul_res_lo, mul_res_hi, mul_n, mul_z, mul_und
  );
endinterface

// File: rtl/arm_mul_seq.sv
// Sequential MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit consuming STEP multiplier bits per cycle.
// Optional feature: define MUL_EARLY_TERM_EN to end CALC once the remaining rs bits are zero.
module arm_mul_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input logic          clk,
  input logic          rst,
  input logic          cpu_en,
  arm_mul_seq_if.slave bus
);
  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic             last;
  logic             reserved;
  logic             is_signed;
  logic             rem_zero;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rs_q;
  logic [PW-1:0]    mcand_q;
  logic [PW-1:0]    prod_q;
  logic [PW-1:0]    prod_next;
  logic [PW-1:0]    rm_ext;
  logic [PW-1:0]    acc_init;
  logic             long_q;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;
  logic             n_q, z_q, und_q;

  assign reserved  = (bus.mul_op[2:1] == 2'b01);
  assign is_signed = bus.mul_op[2] & bus.mul_op[1];

  // rs is treated as unsigned in the shift-add loop; a negative signed rs is
  // corrected up front by pre-subtracting rm_ext << WIDTH from the accumulator.
  always_comb begin
    rm_ext   = is_signed ? {{WIDTH{bus.mul_rm[WIDTH-1]}}, bus.mul_rm}
                         : {{WIDTH{1'b0}}, bus.mul_rm};
    acc_init = '0;
    if (bus.mul_op == 3'b001)
      acc_init = {{WIDTH{1'b0}}, bus.mul_acc_lo};
    else if (bus.mul_op[2] && bus.mul_op[0])
      acc_init = {bus.mul_acc_hi, bus.mul_acc_lo};
    if (is_signed && bus.mul_rs[WIDTH-1])
      acc_init = acc_init - {bus.mul_rm, {WIDTH{1'b0}}};
  end

  assign prod_next = prod_q + mcand_q * {{(PW-STEP){1'b0}}, rs_q[STEP-1:0]};

`ifdef MUL_EARLY_TERM_EN
  assign rem_zero = ((rs_q >> STEP) == '0);
`else
  assign rem_zero = 1'b0;
`endif

  assign last = (cnt_q == CNT_W'(N - 1)) || rem_zero;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    accept  = 1'b0;
    if (cpu_en) begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.mul_start) begin
            accept  = 1'b1;
            state_d = reserved ? DONE : CALC;
          end else if (state_q == DONE) begin
            state_d = IDLE;
          end
        end
        CALC: if (last) state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      rs_q     <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      long_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      und_q    <= 1'b0;
    end else if (cpu_en) begin
      if (accept) begin
        cnt_q   <= '0;
        rs_q    <= bus.mul_rs;
        mcand_q <= rm_ext;
        prod_q  <= acc_init;
        long_q  <= bus.mul_op[2];
        if (reserved) begin
          res_lo_q <= '0;
          res_hi_q <= '0;
          n_q      <= 1'b0;
          z_q      <= 1'b1;
          und_q    <= 1'b1;
        end
      end else if (state_q == CALC) begin
        cnt_q   <= cnt_q + CNT_W'(1);
        rs_q    <= rs_q >> STEP;
        mcand_q <= mcand_q << STEP;
        prod_q  <= prod_next;
        if (last) begin
          res_lo_q <= prod_next[WIDTH-1:0];
          und_q    <= 1'b0;
          if (long_q) begin
            res_hi_q <= prod_next[PW-1:WIDTH];
            n_q      <= prod_next[PW-1];
            z_q      <= (prod_next == '0);
          end else begin
            res_hi_q <= '0;
            n_q      <= prod_next[WIDTH-1];
            z_q      <= (prod_next[WIDTH-1:0] == '0);
          end
        end
      end
    end
  end

  assign bus.mul_busy   = (state_q == CALC);
  assign bus.mul_done   = (state_q == DONE);
  assign bus.mul_res_lo = res_lo_q;
  assign bus.mul_res_hi = res_hi_q;
  assign bus.mul_n      = n_q;
  assign bus.mul_z      = z_q;
  assign bus.mul_und    = und_q;
endmodule

// File: tb/tb_arm_mul_seq.sv
// Self-checking bench for arm_mul_seq: directed cases plus randomized ops checked
// against a plain-arithmetic reference model (honours MUL_EARLY_TERM_EN when defined).
module tb_arm_mul_seq;
  localparam int WIDTH = 32;
  localparam int STEP  = 8;
  localparam int N     = WIDTH / STEP;

  logic clk = 1'b0;
  logic rst;
  logic cpu_en;
  int   n_vec = 0;
  int   n_err = 0;

  arm_mul_seq_if #(.WIDTH(WIDTH)) bus ();

  arm_mul_seq #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk    (clk),
    .rst    (rst),
    .cpu_en (cpu_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] res;
    logic        n;
    logic        z;
    logic        und;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] rm, input logic [31:0] rs,
                                 input logic [31:0] alo, input logic [31:0] ahi);
    exp_t        e;
    logic [63:0] p;
    logic [31:0] lo;
    e = '0;
    p = '0;
    case (op)
      3'b000, 3'b001: begin
        lo    = rm * rs + (op[0] ? alo : 32'd0);
        e.res = {32'd0, lo};
        e.n   = lo[31];
        e.z   = (lo == 32'd0);
      end
      3'b100, 3'b101, 3'b110, 3'b111: begin
        if (op[1]) p = longint'($signed(rm)) * longint'($signed(rs));
        else       p = 64'(rm) * 64'(rs);
        if (op[0]) p = p + {ahi, alo};
        e.res = p;
        e.n   = p[63];
        e.z   = (p == 64'd0);
      end
      default: begin
        e.z   = 1'b1;
        e.und = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Number of CALC cycles the op should take with no stall.
  function automatic int calc_cycles(input logic [2:0] op, input logic [31:0] rs);
`ifdef MUL_EARLY_TERM_EN
    if (op[2:1] == 2'b11 && rs[31]) return N;
    for (int k = 1; k < N; k++)
      if ((rs >> (k * STEP)) == 32'd0) return k;
    return N;
`else
    if (op == 3'b111 && rs == 32'hDEAD_BEEF) return N;
    return N;
`endif
  endfunction

  // Issues one op in the current cycle (IDLE or DONE), optionally stalls the
  // first `stall` cycles and pokes a spurious start in cycle 1, then checks.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rm, input logic [31:0] rs,
                        input logic [31:0] alo, input logic [31:0] ahi,
                        input int stall, input bit inject, input string tag);
    exp_t e;
    int   c, bc, lat;
    e   = model(op, rm, rs, alo, ahi);
    lat = (op[2:1] == 2'b01) ? 0 : calc_cycles(op, rs) + stall;
    bus.mul_op     = op;
    bus.mul_rm     = rm;
    bus.mul_rs     = rs;
    bus.mul_acc_lo = alo;
    bus.mul_acc_hi = ahi;
    bus.mul_start  = 1'b1;
    @(posedge clk); #1;
    bus.mul_start  = 1'b0;
    bus.mul_op     = 3'($urandom_range(0, 7));
    bus.mul_rm     = $urandom;
    bus.mul_rs     = $urandom;
    bus.mul_acc_lo = $urandom;
    bus.mul_acc_hi = $urandom;
    c  = 1;
    bc = 0;
    while (!bus.mul_done && c < 64) begin
      if (bus.mul_busy) bc++;
      cpu_en        = (c > stall);
      bus.mul_start = inject && (c == 1);
      @(posedge clk); #1;
      c++;
    end
    bus.mul_start = 1'b0;
    cpu_en        = 1'b1;
    check({tag, ".done_cycle"}, 64'(c), 64'(lat + 1));
    check({tag, ".busy_cycles"}, 64'(bc), 64'(lat));
    check({tag, ".res"}, {bus.mul_res_hi, bus.mul_res_lo}, e.res);
    check({tag, ".flags_nzu"}, {61'd0, bus.mul_n, bus.mul_z, bus.mul_und}, {61'd0, e.n, e.z, e.und});
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] rm, rs;

    rst            = 1'b0;
    cpu_en         = 1'b1;
    bus.mul_start  = 1'b0;
    bus.mul_op     = 3'd0;
    bus.mul_rm     = '0;
    bus.mul_rs     = '0;
    bus.mul_acc_lo = '0;
    bus.mul_acc_hi = '0;
    #1;
    check("reset.busy_done", {62'd0, bus.mul_busy, bus.mul_done}, 64'd0);
    check("reset.res", {bus.mul_res_hi, bus.mul_res_lo}, 64'd0);
    check("reset.flags_nzu", {61'd0, bus.mul_n, bus.mul_z, bus.mul_und}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    run_op(3'b000, 32'd3, 32'd5, 32'd0, 32'd0, 0, 1'b0, "mul_3x5");

    // A pending done holds through a hold, then drops on the first enabled edge.
    cpu_en = 1'b0;
    @(posedge clk); #1;
    check("hold.done_1", 64'(bus.mul_done), 64'd1);
    @(posedge clk); #1;
    check("hold.done_2", 64'(bus.mul_done), 64'd1);
    cpu_en = 1'b1;
    @(posedge clk); #1;
    check("hold.done_drop", {62'd0, bus.mul_busy, bus.mul_done}, 64'd0);
    check("hold.res_kept", {bus.mul_res_hi, bus.mul_res_lo}, 64'd15);

    run_op(3'b110, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 0, 1'b0, "smull_neg1x2");
    run_op(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 0, 1'b0, "umlal_max");
    run_op(3'b001, 32'd0, 32'd7, 32'd0, 32'd0, 3, 1'b0, "mla_stall3");
    run_op(3'b010, 32'd9, 32'd9, 32'd1, 32'd1, 0, 1'b0, "reserved_010");
    run_op(3'b011, 32'd9, 32'd9, 32'd1, 32'd1, 0, 1'b0, "reserved_011");
    run_op(3'b100, 32'hDEAD_BEEF, 32'h8765_4321, 32'd0, 32'd0, 0, 1'b1, "umull_inject");
    run_op(3'b100, 32'd2, 32'h0000_00FF, 32'd0, 32'd0, 0, 1'b0, "umull_rs_ff");
    run_op(3'b111, 32'h0000_1234, 32'hFFFF_FFFE, 32'h5, 32'h7, 0, 1'b0, "smlal_neg_rs");
    run_op(3'b110, 32'h8000_0000, 32'h0000_0003, 32'd0, 32'd0, 1, 1'b0, "smull_small_rs");
    run_op(3'b000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 0, 1'b0, "mul_zero_rs");

    // Reset in the middle of CALC aborts with every output cleared at once.
    bus.mul_op    = 3'b100;
    bus.mul_rm    = 32'h1234_5678;
    bus.mul_rs    = 32'h8000_0001;
    bus.mul_start = 1'b1;
    @(posedge clk); #1;
    bus.mul_start = 1'b0;
    @(posedge clk); #1;
    check("abort.busy_before", 64'(bus.mul_busy), 64'd1);
    rst = 1'b0;
    #1;
    check("abort.busy_done", {62'd0, bus.mul_busy, bus.mul_done}, 64'd0);
    check("abort.res", {bus.mul_res_hi, bus.mul_res_lo}, 64'd0);
    check("abort.flags_nzu", {61'd0, bus.mul_n, bus.mul_z, bus.mul_und}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk); #1;
      check("abort.no_done", {62'd0, bus.mul_busy, bus.mul_done}, 64'd0);
    end
    run_op(3'b000, 32'd6, 32'd7, 32'd0, 32'd0, 0, 1'b0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       rm = 32'd0;
        1:       rm = 32'hFFFF_FFFF;
        default: rm = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       rs = 32'hFFFF_FFFF;
        1:       rs = $urandom >> $urandom_range(0, 31);
        default: rs = $urandom;
      endcase
      run_op(op, rm, rs, $urandom, $urandom, int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check($sformatf("rand%0d.idle", i), {62'd0, bus.mul_busy, bus.mul_done}, 64'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/arm_mul_seq.md
# arm_mul_seq

Parametrised multi-cycle multiply/multiply-accumulate unit for the ARM core's execute stage. It covers MUL, MLA, UMULL, UMLAL, SMULL and SMLAL. The multiplier operand is consumed STEP bits per cycle, so area can be traded against latency. The core issues one operation at a time, stalls on `mul_busy`, and writes back on `mul_done`. It shares the core's `cpu_en` hold.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH for long ops.
- STEP, 8, rs bits consumed per cycle; must divide WIDTH (1, 2, 4, 8, 16, 32).
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- cpu_en  in  1  global hold; 0 freezes all state and outputs.
- mul_start  in  1  request; accepted only when `cpu_en`=1 and the FSM is in IDLE or DONE.
- mul_op  in  3  000 MUL, 001 MLA, 100 UMULL, 101 UMLAL, 110 SMULL, 111 SMLAL; 010/011 reserved.
- mul_rm, mul_rs  in  WIDTH  multiplicand and multiplier.
- mul_acc_lo, mul_acc_hi  in  WIDTH  accumulator; `mul_acc_hi` is ignored for MLA.
- mul_busy  out  1  high while in CALC.
- mul_done  out  1  high for the DONE cycle.
- mul_res_lo, mul_res_hi  out  WIDTH  result; `mul_res_hi` is 0 for MUL/MLA.
- mul_n, mul_z  out  1  result flags.
- mul_und  out  1  reserved opcode reported with the result.

## Operation
- Operands, op and accumulator are captured at acceptance; later input changes have no effect.
- States and transitions:
  - IDLE: accepted start with a legal op -> CALC; with a reserved op -> DONE.
  - CALC: runs N = WIDTH/STEP enabled cycles, then -> DONE.
  - DONE: asserts `mul_done`. Accepted start -> CALC (back-to-back issue); otherwise -> IDLE.
- Start is ignored while in CALC. No error is flagged.
- Result width and arithmetic:
  - MUL: low WIDTH bits of rm*rs.
  - MLA: low WIDTH bits of rm*rs + acc_lo.
  - UMULL/UMLAL: zero-extend both operands; result = rm*rs (+{acc_hi,acc_lo}) mod 2^(2*WIDTH).
  - SMULL/SMLAL: same, with both operands sign-extended (two's complement).
- Flags: `mul_n` = result MSB (bit 2*WIDTH-1 for long ops, WIDTH-1 otherwise). `mul_z` = every result bit is zero, over 64 bits for long ops.
- Reserved op: result 0, `mul_n`=0, `mul_z`=1, `mul_und`=1. `mul_und` is 0 for legal ops.
- Results and flags update on entry to DONE. They hold until the next DONE.

## Timing
- Reset (asynchronous): FSM -> IDLE. `mul_busy`, `mul_done`, `mul_und`, `mul_n`, `mul_z` = 0; `mul_res_lo`, `mul_res_hi` = 0.
- Latency:
  - Start accepted at edge 0: CALC spans cycles 1..N and `mul_done` is high in cycle N+1.
  - `mul_busy` is high during cycles 1..N.
  - Reserved op: `mul_done` is high in cycle 1.
- `cpu_en`=0: counter, accumulator and FSM freeze. A pending `mul_done` stays high until the first enabled cycle, then drops. Latency stretches by exactly the number of stalled cycles.
- Reset asserted mid-CALC aborts the operation. No `mul_done` is produced; the next op starts cleanly from IDLE.
- Throughput: one operation per N+1 cycles, with no idle bubble between operations.

## Configuration
- MUL_EARLY_TERM_EN defined: CALC ends after the first cycle in which all not-yet-consumed rs bits are zero.
  - CALC is minimum 1 cycle and maximum N.
  - This applies to all ops, including signed ops with non-negative rs. Signed ops with negative rs run the full N cycles.
  - Results are identical to the undefined case.
- MUL_EARLY_TERM_EN undefined: CALC is always exactly N cycles.

## Test plan
- WIDTH=32, STEP=8 (N=4) unless stated.
- MUL rm=3, rs=5 -> `mul_done` 5 cycles after start; res_lo=15, res_hi=0, n=0, z=0, `mul_busy` high 4 cycles.
- SMULL rm=0xFFFFFFFF, rs=2 -> res_hi=0xFFFFFFFF, res_lo=0xFFFFFFFE, n=1.
- UMLAL rm=rs=0xFFFFFFFF, acc={0x00000001,0x00000000} -> res_hi=0xFFFFFFFF, res_lo=0x00000001, n=1, z=0.
- MLA rm=0, rs=7, acc_lo=0, with `cpu_en` low 3 cycles mid-CALC -> z=1, `mul_done` at cycle 8.
- Back-to-back and error cases:
  - Back-to-back: second start issued in the DONE cycle -> second `mul_done` 5 cycles later.
  - Start during CALC -> ignored.
  - op=010 -> `mul_done` next cycle, und=1, z=1.
  - `rst` low mid-CALC -> all outputs 0 immediately.
- With MUL_EARLY_TERM_EN, UMULL rs=0x000000FF, rm=2 -> `mul_done` 2 cycles after start, res_lo=0x1FE. Without the macro -> 5 cycles, same result.
